// File: rtl/acs_array.sv
// ---------------------------------------------------------------------------
// acs_array
// Add-compare-select stage of a rate-1/2, K=3 hard-decision Viterbi decoder
// (generators 7/5 octal). Each valid symbol updates four path costs, shifts
// one survivor decision per state into an 8-bit history, and drives the
// traceback enables for the stage downstream.
//
// Ports:
//   clk                  clock, all state updates on the rising edge
//   rst_n                synchronous reset, active-HIGH despite the name
//   din_valid            symbol strobe; the block updates only when 1
//   din[1:0]             received symbol {c0,c1}
//   ACSxx_selection_o    survivor decision history of state xx, bit 0 newest
//   n_ACSxx_path_cost    normalized path cost of state xx
//   te                   one-cycle pulse after every 8th valid symbol
//   oe                   level, set on the second te pulse, held until reset
//
// Handshake: din_valid is a plain strobe with no backpressure. A symbol is
// consumed on every rising edge where din_valid=1 and reset is not asserted.
// There is no FSM; control state is the 3-bit symbol counter plus the
// filled/oe flags, all visible through te/oe.
// ---------------------------------------------------------------------------
module acs_array (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_valid,
    input  logic [1:0] din,
    output logic [7:0] ACS00_selection_o,
    output logic [7:0] ACS01_selection_o,
    output logic [7:0] ACS10_selection_o,
    output logic [7:0] ACS11_selection_o,
    output logic [3:0] n_ACS00_path_cost,
    output logic [3:0] n_ACS01_path_cost,
    output logic [3:0] n_ACS10_path_cost,
    output logic [3:0] n_ACS11_path_cost,
    output logic       te,
    output logic       oe
);

    logic [3:0] r_cost [4];
    logic [7:0] r_hist [4];
    logic [2:0] r_sym_cnt;
    logic       r_filled;
    logic       r_te;
    logic       r_oe;

    logic [3:0] w_new [4];
    logic       w_dec [4];
    logic       w_norm;
    logic       w_wrap;

    // Hamming distance between the received symbol and the branch output
    // produced by input bit u leaving state s = {s1,s0}.
    function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                                 input logic [1:0] s,
                                                 input logic       u);
        logic c0;
        logic c1;
        c0 = u ^ s[1] ^ s[0];
        c1 = u ^ s[0];
        return {1'b0, sym[1] ^ c0} + {1'b0, sym[0] ^ c1};
    endfunction

    // Next state {u,a} is reached from P0={a,0} and P1={a,1}.
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic       U  = 1'(g / 2);
        localparam logic [1:0] P0 = 2'((g % 2) * 2);
        localparam logic [1:0] P1 = 2'((g % 2) * 2 + 1);

        logic [4:0] w_cand0;
        logic [4:0] w_cand1;
        logic [4:0] w_sel;

        assign w_cand0  = {1'b0, r_cost[P0]} + {3'b000, branch_metric(din, P0, U)};
        assign w_cand1  = {1'b0, r_cost[P1]} + {3'b000, branch_metric(din, P1, U)};
        // Strict less-than: a tie keeps the P0 survivor.
        assign w_dec[g] = (w_cand1 < w_cand0);
        assign w_sel    = w_dec[g] ? w_cand1 : w_cand0;
        // Clamp guard; unreachable while normalization keeps costs bounded.
        assign w_new[g] = (w_sel > 5'd15) ? 4'd15 : w_sel[3:0];
    end

    // All four costs >= 8 means bit 3 is set everywhere; subtracting 8 is
    // then just clearing that bit.
    assign w_norm = w_new[0][3] & w_new[1][3] & w_new[2][3] & w_new[3][3];
    assign w_wrap = din_valid && (r_sym_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            // Encoder starts in state 00, so the other states begin penalized.
            r_cost[0] <= 4'd0;
            r_cost[1] <= 4'd4;
            r_cost[2] <= 4'd4;
            r_cost[3] <= 4'd4;
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= 8'h00;
            end
            r_sym_cnt <= 3'd0;
            r_filled  <= 1'b0;
            r_te      <= 1'b0;
            r_oe      <= 1'b0;
        end else begin
            r_te <= w_wrap;
            if (din_valid) begin
                for (int i = 0; i < 4; i++) begin
                    r_cost[i] <= w_norm ? {1'b0, w_new[i][2:0]} : w_new[i];
                    r_hist[i] <= {r_hist[i][6:0], w_dec[i]};
                end
                r_sym_cnt <= r_sym_cnt + 3'd1;
                if (w_wrap) begin
                    r_filled <= 1'b1;
                    // The first window is warm-up; output starts on the second.
                    if (r_filled) begin
                        r_oe <= 1'b1;
                    end
                end
            end
        end
    end

    assign ACS00_selection_o = r_hist[0];
    assign ACS01_selection_o = r_hist[1];
    assign ACS10_selection_o = r_hist[2];
    assign ACS11_selection_o = r_hist[3];
    assign n_ACS00_path_cost = r_cost[0];
    assign n_ACS01_path_cost = r_cost[1];
    assign n_ACS10_path_cost = r_cost[2];
    assign n_ACS11_path_cost = r_cost[3];
    assign te                = r_te;
    assign oe                = r_oe;

endmodule

// File: tb/tb_acs_array.sv
// ---------------------------------------------------------------------------
// tb_acs_array
// Self-checking bench for acs_array. A behavioural trellis model predicts all
// outputs for every driven cycle; the prediction is queued when stimulus is
// applied and compared after the clock edge that produces it.
// ---------------------------------------------------------------------------
module tb_acs_array;

  logic       clk;
  logic       rst_n;
  logic       din_valid;
  logic [1:0] din;
  logic [7:0] sel00, sel01, sel10, sel11;
  logic [3:0] pc00, pc01, pc10, pc11;
  logic       te, oe;

  acs_array dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .din_valid         (din_valid),
    .din               (din),
    .ACS00_selection_o (sel00),
    .ACS01_selection_o (sel01),
    .ACS10_selection_o (sel10),
    .ACS11_selection_o (sel11),
    .n_ACS00_path_cost (pc00),
    .n_ACS01_path_cost (pc01),
    .n_ACS10_path_cost (pc10),
    .n_ACS11_path_cost (pc11),
    .te                (te),
    .oe                (oe)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int te_cnt   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  int         m_cost [4];
  logic [7:0] m_hist [4];
  int         m_cnt;
  logic       m_filled;
  logic       m_oe;
  logic       m_te;
  int         m_max_cand = 0;
  int         norm_cnt   = 0;

  function automatic logic [1:0] encode(input int s, input int u);
    logic c0, c1;
    c0 = 1'(u ^ (s >> 1) ^ s);
    c1 = 1'(u ^ s);
    return {c0, c1};
  endfunction

  task automatic model_step(input logic rst, input logic v, input logic [1:0] sym);
    int cand_p0 [4];
    int cand_p1 [4];
    int nc [4];
    int ns, bm;
    logic [1:0] code;
    logic dec;
    if (rst) begin
      m_cost = '{0, 4, 4, 4};
      for (int i = 0; i < 4; i++) m_hist[i] = 8'h00;
      m_cnt = 0; m_filled = 0; m_oe = 0; m_te = 0;
      return;
    end
    m_te = v && (m_cnt == 7);
    if (!v) return;
    // Forward enumeration of every branch (s, u) -> {u, s1}.
    for (int s = 0; s < 4; s++) begin
      for (int u = 0; u < 2; u++) begin
        ns   = u * 2 + (s >> 1);
        code = encode(s, u);
        bm   = int'(code[1] != sym[1]) + int'(code[0] != sym[0]);
        if (m_cost[s] + bm > m_max_cand) m_max_cand = m_cost[s] + bm;
        if (s % 2 == 1) cand_p1[ns] = m_cost[s] + bm;
        else            cand_p0[ns] = m_cost[s] + bm;
      end
    end
    for (int k = 0; k < 4; k++) begin
      dec   = (cand_p1[k] < cand_p0[k]);
      nc[k] = dec ? cand_p1[k] : cand_p0[k];
      if (nc[k] > 15) nc[k] = 15;
      m_hist[k] = {m_hist[k][6:0], dec};
    end
    if (nc[0] >= 8 && nc[1] >= 8 && nc[2] >= 8 && nc[3] >= 8) begin
      norm_cnt++;
      for (int k = 0; k < 4; k++) nc[k] = nc[k] - 8;
    end
    for (int k = 0; k < 4; k++) m_cost[k] = nc[k];
    if (m_cnt == 7) begin
      m_cnt = 0;
      if (m_filled) m_oe = 1;
      m_filled = 1;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [49:0] model_pack();
    return {m_hist[0], m_hist[1], m_hist[2], m_hist[3],
            4'(m_cost[0]), 4'(m_cost[1]), 4'(m_cost[2]), 4'(m_cost[3]), m_te, m_oe};
  endfunction

  function automatic logic [49:0] dut_pack();
    return {sel00, sel01, sel10, sel11, pc00, pc01, pc10, pc11, te, oe};
  endfunction

  function automatic logic [3:0] dut_cost(input int s);
    case (s)
      0:       return pc00;
      1:       return pc01;
      2:       return pc10;
      default: return pc11;
    endcase
  endfunction

  function automatic logic [7:0] dut_hist(input int s);
    case (s)
      0:       return sel00;
      1:       return sel01;
      2:       return sel10;
      default: return sel11;
    endcase
  endfunction

  function automatic int dut_min_cost();
    int m;
    m = 15;
    for (int s = 0; s < 4; s++) if (int'(dut_cost(s)) < m) m = int'(dut_cost(s));
    return m;
  endfunction

  // ---------------- scoreboard ----------------
  logic [49:0] exp_q[$];

  task automatic compare_out();
    logic [49:0] e;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_val("outputs", 64'(dut_pack()), 64'(e));
    end
    if (te) te_cnt++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic v, input logic [1:0] sym);
    rst_n     = rst;
    din_valid = v;
    din       = sym;
    model_step(rst, v, sym);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset();
    step(1'b1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
    te_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  int         true_st [9];
  logic [1:0] enc_sym [8];
  int         bits [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  logic [15:0] traced, expect_trace;
  int         st, d;

  initial begin
    rst_n = 1'b0; din_valid = 1'b0; din = 2'b00;
    @(negedge clk);

    // Reset state
    do_reset();
    check_val("rst_costs", {pc00, pc01, pc10, pc11}, 64'h0444);
    check_val("rst_te_oe", {te, oe}, 64'd0);

    // One all-zero symbol
    step(1'b0, 1'b1, 2'b00);
    check_val("one_sym_costs", {pc00, pc01, pc10, pc11}, 64'h0525);
    check_val("one_sym_hist", {sel00, sel01, sel10, sel11}, 64'h0);

    // 16 all-zero symbols: te at 8 and 16, oe from 16
    for (int i = 1; i < 8; i++) step(1'b0, 1'b1, 2'b00);
    check_val("te_at_8", te, 64'd1);
    check_val("te_cnt_8", te_cnt, 64'd1);
    check_val("oe_after_8", oe, 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'b00);
    check_val("te_cnt_16", te_cnt, 64'd2);
    check_val("oe_after_16", oe, 64'd1);
    check_val("hist00_zero", sel00, 64'h00);
    step(1'b0, 1'b0, 2'b11);
    check_val("te_pulse_one", te, 64'd0);

    // Gapped input
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
      step(1'b0, 1'b0, 2'($urandom_range(0, 3)));
    end
    check_val("gap_te_cnt", te_cnt, 64'd1);

    // Error-free encoded sequence
    true_st[0] = 0;
    for (int i = 0; i < 8; i++) begin
      enc_sym[i]    = encode(true_st[i], bits[i]);
      true_st[i+1]  = bits[i] * 2 + (true_st[i] >> 1);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, enc_sym[i]);
      check_val($sformatf("true_cost_%0d", i), dut_cost(true_st[i+1]), 64'd0);
    end
    // Trace back from the true final state through the stored decisions.
    st = true_st[8];
    traced = '0; expect_trace = '0;
    for (int k = 0; k < 8; k++) begin
      d  = int'(dut_hist(st)[k]);
      st = (st % 2) * 2 + d;
      traced[2*k +: 2]       = 2'(st);
      expect_trace[2*k +: 2] = 2'(true_st[7-k]);
    end
    check_val("traceback", traced, expect_trace);

    // Single bit error in symbol 3
    do_reset();
    step(1'b0, 1'b1, enc_sym[0]);
    step(1'b0, 1'b1, enc_sym[1]);
    step(1'b0, 1'b1, enc_sym[2] ^ 2'b10);
    check_val("err_min_cost", dut_min_cost(), 64'd1);

    // Random symbols
    do_reset();
    norm_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      step(1'b0, $urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)));
      if (dut_min_cost() > 7) check_val("min_le_7", dut_min_cost(), 64'd7);
    end
    check_val("no_saturation", m_max_cand > 15, 64'd0);
    check_val("norm_seen", norm_cnt > 0, 64'd1);

    // Reset mid-window
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
    step(1'b1, 1'b1, 2'b11);
    te_cnt = 0;
    check_val("midrst_costs", {pc00, pc01, pc10, pc11}, 64'h0444);
    check_val("midrst_hist", {sel00, sel01, sel10, sel11}, 64'h0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
    check_val("midrst_no_te_7", te_cnt, 64'd0);
    step(1'b0, 1'b1, 2'($urandom_range(0, 3)));
    check_val("midrst_te_8", te_cnt, 64'd1);
    check_val("midrst_oe", oe, 64'd0);

    check_val("queue_drained", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acs_array.md
# acs_array

Add-compare-select stage of the rate-1/2, K=3 hard-decision Viterbi decoder (generators 7/5 octal). It consumes one received 2-bit symbol per valid cycle and updates four path costs. It shifts one survivor decision per state into 8-bit histories and issues the traceback and output enables. The traceback stage sits directly downstream and consumes every output of this block.

## Interface
Parameters: none (trellis, history depth 8 and cost width 4 are fixed by the traceback stage).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous, active-high (asserted = 1; name kept for codebase consistency)
- din_valid  input  1  symbol strobe; block updates only when 1
- din  input  2  received symbol {c0,c1}; din[1]=c0, din[0]=c1
- ACS00_selection_o … ACS11_selection_o  output  8 each  survivor decision histories; bit 0 newest
- n_ACS00_path_cost … n_ACS11_path_cost  output  4 each  normalized path costs
- te  output  1  traceback enable pulse
- oe  output  1  output enable level

## Operation
- State s={s1,s0}={u[t-1],u[t-2]}. Input bit u gives next state {u,s1}, c0=u^s1^s0 and c1=u^s0.
- Branch metric bm = Hamming distance(din, {c0,c1}), range 0..2.
- Next state {u,a} has predecessors P0={a,0} and P1={a,1}. cand0=cost(P0)+bm0 and cand1=cost(P1)+bm1, summed at 5 bits.
- Decision = 1 iff cand1 < cand0. A tie selects 0 (P0). New cost = selected candidate.
- Normalization: if all four new costs are ≥8, subtract 8 from each before storing. Otherwise store unchanged.
- Saturation guard: any candidate >15 is clamped to 15. This must never occur in legal operation, and the bench asserts it does not.
- Survivor update: each history becomes {history[6:0], decision}, all four updated in the same cycle.
- Control:
  - 3-bit sym_cnt increments per valid symbol and wraps 7→0.
  - `filled` flag sets when sym_cnt wraps for the first time.
  - `te` = 1 for exactly the cycle following each valid update that wraps sym_cnt, so it pulses every 8 valid symbols.
  - `oe` sets at the second te pulse (first window is warm-up) and stays 1 until reset.
- din_valid=0: costs, histories, sym_cnt, filled and oe all hold, and te=0.

## Timing
- Reset values: n_ACS00_path_cost=0, the other three costs=4 (encoder starts in state 00). All selection outputs=8'h00, te=0, oe=0, sym_cnt=0, filled=0.
- Latency: a symbol sampled at edge k appears in costs and histories after edge k (one cycle). All outputs are registered.
- te asserts on the same edge that the 8th symbol's results become visible, so the traceback stage sees a full, consistent window while te=1.
- Back-to-back valid symbols are supported at one per clock with no bubbles.
- Reset asserted mid-window: everything returns to reset values on that edge, and the symbol presented in that cycle is discarded. The window count restarts from 0.
- Reset has priority over din_valid.

## Test plan
- Reset then din=2'b00 for one valid cycle → costs 00/01/10/11 = 0/5/2/5; all histories 8'h00.
- din=2'b00 for 8 consecutive valid cycles → te pulses once, on the edge of the 8th update; oe stays 0. Continuing to 16 → second te pulse, oe=1 from then on. Histories for state 00 stay 8'h00.
- Gapped input (din_valid toggling 1/0) for 8 valid symbols → te still fires after the 8th valid symbol; outputs are unchanged during every din_valid=0 cycle.
- Encode u=1,0,1,1,0,0,1,0 with the 7/5 encoder and drive it error-free → the cost of the true encoder state is 0 after each update, and stored decisions trace the true path. Flip one bit in symbol 3 → minimum cost becomes 1.
- Drive 500 random symbols → no candidate exceeds 15, and min cost ≤7 after every update. Normalization events occur, each shifting all four costs by exactly 8.
- Assert rst_n for one cycle after 5 valid symbols → all outputs return to reset values next edge. The next te appears only after 8 further valid symbols.
